// File: rtl/i2c_tgt.sv
// Byte-level I2C target front end: START/STOP decode, address/data shifting, ACK and read-data drive.
// Optional I2C_GLITCH_FILTER_EN adds a 4-sample stability filter on the synchronized SCL/SDA lines.
module i2c_tgt (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [6:0] dev,
    input  logic       ok,
    output logic       dir,
    output logic [7:0] in,
    input  logic [7:0] out,
    output logic       ack,
    output logic       start,
    output logic       stop
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEV_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_IGNORE
    } state_e;

    state_e state_q, state_d;

    logic [1:0]        scl_sync_q, sda_sync_q;
    logic              scl_s, sda_s;
    logic              scl_prev_q, sda_prev_q;
    logic              scl_rise, scl_fall, start_ev, stop_ev;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] sh_q, sh_d;
    logic [DEV_W-1:0]  dev_q, dev_d;
    logic              dir_q, dir_d;
    logic [BYTE_W-1:0] in_q, in_d;
    logic              ack_q, ack_d;
    logic              start_q, start_d;
    logic              stop_q, stop_d;
    logic              sda_oe_q, sda_oe_d;

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [3:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    // Filtered level moves only after four consecutive equal samples
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_hist_q <= 4'hF;
            sda_hist_q <= 4'hF;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[2:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[2:0], sda_sync_q[1]};
            if (&scl_hist_q)       scl_filt_q <= 1'b1;
            else if (~|scl_hist_q) scl_filt_q <= 1'b0;
            if (&sda_hist_q)       sda_filt_q <= 1'b1;
            else if (~|sda_hist_q) sda_filt_q <= 1'b0;
        end
    end

    assign scl_s = scl_filt_q;
    assign sda_s = sda_filt_q;
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // START/STOP need SCL high on both samples so a simultaneous SCL fall never masquerades as one
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_ev) begin
            state_d = S_ADDR;
        end else if (stop_ev) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR:  if (scl_fall && cnt_q == CNT_W'(8)) state_d = ok ? S_AACK : S_IGNORE;
                S_AACK:  if (scl_fall) state_d = dir_q ? S_RDATA : S_WDATA;
                S_WDATA: if (scl_fall && cnt_q == CNT_W'(8)) state_d = S_WACK;
                S_WACK:  if (scl_fall) state_d = S_WDATA;
                S_RDATA: if (scl_fall && cnt_q == CNT_W'(8)) state_d = S_RACK;
                S_RACK: begin
                    if (scl_rise && sda_s) state_d = S_IGNORE;
                    else if (scl_fall)     state_d = S_RDATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and pin-drive next values; ack drops on any SCL fall unless re-set below
    always_comb begin
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        dev_d    = dev_q;
        dir_d    = dir_q;
        in_d     = in_q;
        sda_oe_d = sda_oe_q;
        ack_d    = ack_q & ~scl_fall;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        if (start_ev) begin
            start_d  = 1'b1;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
        end else if (stop_ev) begin
            stop_d   = 1'b1;
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[6:0], sda_s};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(6)) dev_d = {sh_q[5:0], sda_s};
                        if (cnt_q == CNT_W'(7)) dir_d = sda_s;
                    end else if (scl_fall && cnt_q == CNT_W'(8)) begin
                        cnt_d    = '0;
                        sda_oe_d = ok;
                        ack_d    = ok;
                    end
                end
                S_AACK: begin
                    if (scl_fall) begin
                        if (dir_q) begin
                            sh_d     = out;
                            sda_oe_d = ~out[7];
                            cnt_d    = CNT_W'(1);
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                        end
                    end
                end
                S_WDATA: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[6:0], sda_s};
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (scl_fall && cnt_q == CNT_W'(8)) begin
                        in_d     = sh_q;
                        sda_oe_d = 1'b1;
                        ack_d    = 1'b1;
                        cnt_d    = '0;
                    end
                end
                S_WACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == CNT_W'(8)) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                        end else begin
                            sh_d     = {sh_q[6:0], 1'b0};
                            sda_oe_d = ~sh_q[6];
                            cnt_d    = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise && !sda_s) begin
                        ack_d = 1'b1;
                    end else if (scl_fall) begin
                        sh_d     = out;
                        sda_oe_d = ~out[7];
                        cnt_d    = CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            sh_q     <= '0;
            dev_q    <= '0;
            dir_q    <= 1'b0;
            in_q     <= '0;
            ack_q    <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            sda_oe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            dev_q    <= dev_d;
            dir_q    <= dir_d;
            in_q     <= in_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    assign sda   = sda_oe_q ? 1'b0 : 1'bz;
    assign dev   = dev_q;
    assign dir   = dir_q;
    assign in    = in_q;
    assign ack   = ack_q;
    assign start = start_q;
    assign stop  = stop_q;

endmodule

// File: tb/tb_i2c_tgt.sv
// Scoreboard bench for i2c_tgt: a bus controller issues transactions, DUT events and bus
// observations are checked against queued expectations.
module tb_i2c_tgt;

    localparam int unsigned Q = 10;   // clk cycles per quarter SCL period

    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_STOP  = 2'd1;
    localparam logic [1:0] K_ACK   = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] data;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset_r = 1'b1;
    logic       scl_r = 1'b1;
    logic       ctl_low = 1'b0;
    wire        sda;
    logic [6:0] dev_w;
    logic       ok_w;
    logic       dir_w;
    logic [7:0] in_w;
    logic [7:0] out_r = 8'h00;
    logic       ack_w;
    logic       start_w;
    logic       stop_w;

    int n_checks = 0;
    int n_fail   = 0;

    evt_t       exp_dut_q[$];
    logic [7:0] exp_bus_q[$];

    logic [7:0] out_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int         ridx = 0;
    logic       dev_ack_prev = 1'b0;
    logic       mon_ack_prev = 1'b0;

    pullup (sda);
    assign sda = ctl_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_tgt dut (
        .clk   (clk),
        .reset (reset_r),
        .scl   (scl_r),
        .sda   (sda),
        .dev   (dev_w),
        .ok    (ok_w),
        .dir   (dir_w),
        .in    (in_w),
        .out   (out_r),
        .ack   (ack_w),
        .start (start_w),
        .stop  (stop_w)
    );

    // Device model: claims 0x26 and supplies the next read byte on each ack rise of a read
    assign ok_w = (dev_w == 7'h26);
    always @(posedge clk) begin
        dev_ack_prev <= ack_w;
        if (ack_w && !dev_ack_prev && dir_w && ridx < 4) begin
            out_r <= out_tab[ridx];
            ridx  <= ridx + 1;
        end
    end

    task automatic exp_evt(input logic [1:0] k, input logic [15:0] d);
        evt_t e;
        e.kind = k;
        e.data = d;
        exp_dut_q.push_back(e);
    endtask

    task automatic exp_ack(input logic d, input logic [6:0] dv, input logic [7:0] i);
        exp_evt(K_ACK, {d, dv, i});
    endtask

    task automatic exp_bus(input logic [7:0] v);
        exp_bus_q.push_back(v);
    endtask

    task automatic dut_event(input logic [1:0] k, input logic [15:0] d, input string nm);
        evt_t e;
        n_checks++;
        if (exp_dut_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s got data=%h expected no event", nm, d);
        end else begin
            e = exp_dut_q.pop_front();
            if (e.kind != k || e.data != d) begin
                n_fail++;
                $display("FAIL evt_%s got kind=%0d data=%h expected kind=%0d data=%h",
                         nm, k, d, e.kind, e.data);
            end
        end
    endtask

    task automatic bus_obs(input logic [7:0] v, input string nm);
        logic [7:0] e;
        n_checks++;
        if (exp_bus_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_bus_%s got=%h expected none", nm, v);
        end else begin
            e = exp_bus_q.pop_front();
            if (v !== e) begin
                n_fail++;
                $display("FAIL bus_%s got=%h expected=%h", nm, v, e);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: every DUT event is matched against the expectation queue
    always @(negedge clk) begin
        mon_ack_prev <= ack_w;
        if (start_w) dut_event(K_START, 16'h0000, "start");
        if (stop_w)  dut_event(K_STOP, 16'h0000, "stop");
        if (ack_w && !mon_ack_prev) dut_event(K_ACK, {dir_w, dev_w, in_w}, "ack");
    end

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        wait_clk(Q);
        ctl_low = ~b;
        wait_clk(Q);
        scl_r = 1'b1;
        wait_clk(Q);
        seen = sda;
        wait_clk(Q);
        scl_r = 1'b0;
    endtask

    task automatic bus_start();
        wait_clk(Q);
        ctl_low = 1'b0;
        wait_clk(Q);
        scl_r = 1'b1;
        wait_clk(2 * Q);
        ctl_low = 1'b1;
        wait_clk(2 * Q);
        scl_r = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q);
        ctl_low = 1'b1;
        wait_clk(Q);
        scl_r = 1'b1;
        wait_clk(2 * Q);
        ctl_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        bus_obs({7'b0, s}, "ackbit");
    endtask

    task automatic read_byte(input logic nack);
        logic       s;
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            v = {v[6:0], s};
        end
        bus_obs(v, "rdbyte");
        clock_bit(nack, s);
        if (nack) begin
            wait_clk(Q / 2);
            bus_obs({7'b0, sda}, "released");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clk(5);
        reset_r = 1'b0;
        wait_clk(1);
        chk("reset_outs", 16'({dev_w, dir_w}), 16'h0000);
        chk("reset_in_ack", 16'({in_w, ack_w, start_w, stop_w, sda}), 16'h0001);
        wait_clk(10);

        // Write: 0x4C, 0x0A, 0x80
        exp_evt(K_START, 16'h0000);
        exp_ack(1'b0, 7'h26, 8'h00); exp_bus(8'h00);
        exp_ack(1'b0, 7'h26, 8'h0A); exp_bus(8'h00);
        exp_ack(1'b0, 7'h26, 8'h80); exp_bus(8'h00);
        exp_evt(K_STOP, 16'h0000);
        bus_start();
        write_byte(8'h4C);
        write_byte(8'h0A);
        write_byte(8'h80);
        bus_stop();
        chk("write_in_held", 16'(in_w), 16'h0080);

        // Unclaimed address: no ACK on the address or following byte
        exp_evt(K_START, 16'h0000);
        exp_bus(8'h01);
        exp_bus(8'h01);
        exp_evt(K_STOP, 16'h0000);
        bus_start();
        write_byte(8'h60);
        write_byte(8'h55);
        bus_stop();

        // Read: 0x4D then 0x11, 0x22 (ACKed), 0x33 (NACKed)
        exp_evt(K_START, 16'h0000);
        exp_ack(1'b1, 7'h26, 8'h80); exp_bus(8'h00);
        exp_bus(8'h11); exp_ack(1'b1, 7'h26, 8'h80);
        exp_bus(8'h22); exp_ack(1'b1, 7'h26, 8'h80);
        exp_bus(8'h33); exp_bus(8'h01);
        exp_evt(K_STOP, 16'h0000);
        bus_start();
        write_byte(8'h4D);
        read_byte(1'b0);
        read_byte(1'b0);
        read_byte(1'b1);
        bus_stop();

        // Repeated START turning a write into a read
        exp_evt(K_START, 16'h0000);
        exp_ack(1'b0, 7'h26, 8'h80); exp_bus(8'h00);
        exp_ack(1'b0, 7'h26, 8'h05); exp_bus(8'h00);
        exp_evt(K_START, 16'h0000);
        exp_ack(1'b1, 7'h26, 8'h05); exp_bus(8'h00);
        exp_bus(8'h44); exp_bus(8'h01);
        exp_evt(K_STOP, 16'h0000);
        bus_start();
        write_byte(8'h4C);
        write_byte(8'h05);
        bus_start();
        write_byte(8'h4D);
        read_byte(1'b1);
        bus_stop();

        // Reset during the 4th bit of a write data byte (0xB0), then a fresh transfer
        exp_evt(K_START, 16'h0000);
        exp_ack(1'b0, 7'h26, 8'h05); exp_bus(8'h00);
        bus_start();
        write_byte(8'h4C);
        begin
            logic s;
            clock_bit(1'b1, s);
            clock_bit(1'b0, s);
            clock_bit(1'b1, s);
        end
        wait_clk(Q);
        ctl_low = 1'b0;
        wait_clk(Q);
        scl_r = 1'b1;
        wait_clk(Q);
        reset_r = 1'b1;
        wait_clk(1);
        chk("midreset_outs", 16'({dev_w, dir_w}), 16'h0000);
        chk("midreset_in_ack", 16'({in_w, ack_w, start_w, stop_w, sda}), 16'h0001);
        reset_r = 1'b0;
        wait_clk(Q);
        scl_r = 1'b0;
        exp_evt(K_START, 16'h0000);
        exp_ack(1'b0, 7'h26, 8'h00); exp_bus(8'h00);
        exp_ack(1'b0, 7'h26, 8'h5A); exp_bus(8'h00);
        exp_evt(K_STOP, 16'h0000);
        bus_start();
        write_byte(8'h4C);
        write_byte(8'h5A);
        bus_stop();

        // 2-clk SDA low glitch with SCL high on an idle bus
`ifndef I2C_GLITCH_FILTER_EN
        exp_evt(K_START, 16'h0000);
        exp_evt(K_STOP, 16'h0000);
`endif
        wait_clk(10);
        ctl_low = 1'b1;
        wait_clk(2);
        ctl_low = 1'b0;
        wait_clk(40);

        chk("dut_queue_drained", 16'(exp_dut_q.size()), 16'h0000);
        chk("bus_queue_drained", 16'(exp_bus_q.size()), 16'h0000);
        chk("read_bytes_served", 16'(ridx), 16'h0004);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
